branch_resolve_predict: RTL and testbench

Parametrised branch-resolution and prediction block for the OTTER execute stage. It resolves conditional branches, JAL and JALR from the register operands and decoded instruction fields, producing PC_SOURCE. It also maintains a branch history table (BHT) of 2-bit saturating counters that fetch reads for a taken/not-taken prediction. Execute-stage resolutions update the table, raise a registered mispredict pulse and increment saturating statistics counters.

---
 rtl/bcg_pkg.sv | 46 ++++
 rtl/branch_cond_eval.sv | 50 +++++
 rtl/branch_resolve_predict.sv | 107 ++++++++++
 tb/tb_branch_resolve_predict.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcg_pkg.sv
// Shared types and helpers for the OTTER branch resolve / predict block.
//   - opcode constants for conditional branches, JAL and JALR
//   - funct3 encodings of the conditional branches
//   - PC_SOURCE encoding and 2-bit BHT counter states
//   - bht_next: saturating 2-bit counter step
package bcg_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JALR   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JAL    = 2'b11
  } pc_source_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    bht_state_t n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation.
//   rs1, rs2      : register operands
//   opcode, funct3: decoded instruction fields
//   taken         : legal conditional branch whose condition holds
//   valid_branch  : opcode is BRANCH and funct3 is a defined branch
module branch_cond_eval
  import bcg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            valid_branch
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   eq;
  logic                   lt;
  logic                   ltu;
  logic                   cond;
  logic                   legal_f3;

  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign eq    = (rs1 == rs2);
  assign lt    = (rs1_s < rs2_s);
  assign ltu   = (rs1 < rs2);

  always_comb begin
    cond     = 1'b0;
    legal_f3 = 1'b1;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: legal_f3 = 1'b0;
    endcase
  end

  assign valid_branch = (opcode == OP_BRANCH) && legal_f3;
  assign taken        = valid_branch && cond;

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch resolution and 2-bit BHT prediction for the OTTER execute stage.
//   IF_PC / IF_PRED_TAKEN : zero-cycle table lookup for fetch
//   EX_* / RS1 / RS2 / IR_*: instruction being resolved in EX
//   PC_SOURCE / BR_TAKEN  : combinational resolution (not gated by EX_VALID)
//   MISPREDICT            : registered pulse, one cycle per mispredict
//   BR_COUNT / MISS_COUNT : saturating statistics
module branch_resolve_predict
  import bcg_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int INDEX_LSB = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [XLEN-1:0]  IF_PC,
  output logic             IF_PRED_TAKEN,
  input  logic             EX_VALID,
  input  logic [XLEN-1:0]  EX_PC,
  input  logic             EX_PRED_TAKEN,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  RS2,
  input  logic [6:0]       IR_OPCODE,
  input  logic [2:0]       IR_FUNCT,
  output logic [1:0]       PC_SOURCE,
  output logic             BR_TAKEN,
  output logic             MISPREDICT,
  output logic [CNT_W-1:0] BR_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             cond_taken;
  logic             valid_branch;
  logic             update;
  pc_source_t       pc_src;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_pc_bits;

  bht_state_t       bht_q [BHT_DEPTH];
  bht_state_t       bht_d [BHT_DEPTH];
  logic [CNT_W-1:0] br_count_q,   br_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;
  logic             mispredict_q, mispredict_d;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .rs1          (RS1),
    .rs2          (RS2),
    .opcode       (IR_OPCODE),
    .funct3       (IR_FUNCT),
    .taken        (cond_taken),
    .valid_branch (valid_branch)
  );

  assign if_idx         = IF_PC[INDEX_LSB +: IDX_W];
  assign ex_idx         = EX_PC[INDEX_LSB +: IDX_W];
  assign unused_pc_bits = ^{IF_PC, EX_PC};

  always_comb begin
    pc_src = PC_PLUS4;
    if (IR_OPCODE == OP_JAL)       pc_src = PC_JAL;
    else if (IR_OPCODE == OP_JALR) pc_src = PC_JALR;
    else if (cond_taken)           pc_src = PC_BRANCH;
  end

  assign PC_SOURCE = pc_src;
  assign BR_TAKEN  = cond_taken;
  assign update    = valid_branch && EX_VALID;

  // Lookup reads the registered table directly: a same-cycle update to the
  // same entry is visible only after the edge.
  assign IF_PRED_TAKEN = bht_q[if_idx][1];

  always_comb begin
    bht_d        = bht_q;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    mispredict_d = update && (cond_taken != EX_PRED_TAKEN);
    if (update) begin
      bht_d[ex_idx] = bht_next(bht_q[ex_idx], cond_taken);
      if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
    end
    if (mispredict_d && (miss_count_q != '1)) miss_count_d = miss_count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= WNT;
      br_count_q   <= '0;
      miss_count_q <= '0;
      mispredict_q <= 1'b0;
    end else begin
      bht_q        <= bht_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign MISPREDICT = mispredict_q;
  assign BR_COUNT   = br_count_q;
  assign MISS_COUNT = miss_count_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
module tb_branch_resolve_predict;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [6:0] OPB  = 7'b1100011;
  localparam logic [6:0] OPJ  = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [XLEN-1:0]  IF_PC;
  logic             IF_PRED_TAKEN;
  logic             EX_VALID;
  logic [XLEN-1:0]  EX_PC;
  logic             EX_PRED_TAKEN;
  logic [XLEN-1:0]  RS1;
  logic [XLEN-1:0]  RS2;
  logic [6:0]       IR_OPCODE;
  logic [2:0]       IR_FUNCT;
  logic [1:0]       PC_SOURCE;
  logic             BR_TAKEN;
  logic             MISPREDICT;
  logic [CNT_W-1:0] BR_COUNT;
  logic [CNT_W-1:0] MISS_COUNT;

  int n_run  = 0;
  int n_fail = 0;

  branch_resolve_predict #(
    .XLEN(XLEN), .BHT_DEPTH(64), .INDEX_LSB(2), .CNT_W(CNT_W)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .IF_PC         (IF_PC),
    .IF_PRED_TAKEN (IF_PRED_TAKEN),
    .EX_VALID      (EX_VALID),
    .EX_PC         (EX_PC),
    .EX_PRED_TAKEN (EX_PRED_TAKEN),
    .RS1           (RS1),
    .RS2           (RS2),
    .IR_OPCODE     (IR_OPCODE),
    .IR_FUNCT      (IR_FUNCT),
    .PC_SOURCE     (PC_SOURCE),
    .BR_TAKEN      (BR_TAKEN),
    .MISPREDICT    (MISPREDICT),
    .BR_COUNT      (BR_COUNT),
    .MISS_COUNT    (MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred);
    EX_VALID      = v;
    IR_OPCODE     = op;
    IR_FUNCT      = f3;
    RS1           = a;
    RS2           = b;
    EX_PC         = pc;
    EX_PRED_TAKEN = pred;
  endtask

  initial begin
    RST_N = 1'b0;
    IF_PC = 32'h0;
    drive(1'b0, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    settle();

    // Reset state
    IF_PC = 32'h0;  settle();
    check("rst_pred_0", IF_PRED_TAKEN, 1'b0);
    IF_PC = 32'hFC; settle();
    check("rst_pred_fc", IF_PRED_TAKEN, 1'b0);
    check("rst_br", BR_COUNT, 0);
    check("rst_miss", MISS_COUNT, 0);
    check("rst_mp", MISPREDICT, 1'b0);

    // beq taken at 0x40, predicted not-taken; same-cycle lookup sees old entry
    IF_PC = 32'h40;
    drive(1'b1, OPB, 3'b000, 32'd5, 32'd5, 32'h40, 1'b0);
    settle();
    check("beq_pcsrc", PC_SOURCE, 2'b10);
    check("beq_taken", BR_TAKEN, 1'b1);
    check("same_cyc_pre", IF_PRED_TAKEN, 1'b0);
    tick();
    check("beq_mp", MISPREDICT, 1'b1);
    check("same_cyc_post", IF_PRED_TAKEN, 1'b1);
    check("beq_br", BR_COUNT, 1);
    check("beq_miss", MISS_COUNT, 1);
    EX_VALID = 1'b0;
    tick();
    check("beq_mp_pulse_end", MISPREDICT, 1'b0);
    check("idle_pred_hold", IF_PRED_TAKEN, 1'b1);

    // Compare variants, EX_VALID low (combinational still driven)
    drive(1'b0, OPB, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0); settle();
    check("blt_pcsrc", PC_SOURCE, 2'b10);
    IR_FUNCT = 3'b110; settle();
    check("bltu_pcsrc", PC_SOURCE, 2'b00);
    IR_FUNCT = 3'b101; settle();
    check("bge_pcsrc", PC_SOURCE, 2'b00);
    IR_FUNCT = 3'b111; settle();
    check("bgeu_pcsrc", PC_SOURCE, 2'b10);
    IR_FUNCT = 3'b001; settle();
    check("bne_pcsrc", PC_SOURCE, 2'b10);
    IR_FUNCT = 3'b000; settle();
    check("beq_ne_pcsrc", PC_SOURCE, 2'b00);
    tick();
    check("novalid_br", BR_COUNT, 1);
    check("novalid_mp", MISPREDICT, 1'b0);

    // Training sequence at 0x80 (entry 32)
    IF_PC = 32'h80;
    drive(1'b1, OPB, 3'b000, 32'd5, 32'd5, 32'h80, 1'b0); // WNT -> WT, miss
    tick();
    check("tr1_pred", IF_PRED_TAKEN, 1'b1);
    check("tr1_mp", MISPREDICT, 1'b1);
    EX_PRED_TAKEN = 1'b1;                                 // WT -> ST
    tick();
    check("tr2_pred", IF_PRED_TAKEN, 1'b1);
    check("tr2_mp", MISPREDICT, 1'b0);
    tick();                                               // ST -> ST
    check("tr3_pred", IF_PRED_TAKEN, 1'b1);
    tick();                                               // ST -> ST
    check("tr4_pred", IF_PRED_TAKEN, 1'b1);
    IR_FUNCT = 3'b001;                                    // bne, equal operands: not taken
    settle();
    check("tr5_pcsrc", PC_SOURCE, 2'b00);
    tick();                                               // ST -> WT, miss
    check("tr5_pred", IF_PRED_TAKEN, 1'b1);
    check("tr5_mp", MISPREDICT, 1'b1);
    tick();                                               // WT -> WNT, miss
    check("tr6_pred", IF_PRED_TAKEN, 1'b0);
    check("tr6_mp", MISPREDICT, 1'b1);
    check("tr_br", BR_COUNT, 7);
    check("tr_miss", MISS_COUNT, 4);

    // JAL / JALR / illegal funct3: no table or counter effect
    IF_PC = 32'h40;
    drive(1'b1, OPJ, 3'b000, 32'd5, 32'd5, 32'h40, 1'b0); settle();
    check("jal_pcsrc", PC_SOURCE, 2'b11);
    check("jal_taken", BR_TAKEN, 1'b0);
    tick();
    check("jal_mp", MISPREDICT, 1'b0);
    IR_OPCODE = OPJR; settle();
    check("jalr_pcsrc", PC_SOURCE, 2'b01);
    tick();
    check("jalr_mp", MISPREDICT, 1'b0);
    drive(1'b1, OPB, 3'b010, 32'd5, 32'd5, 32'h40, 1'b1); settle();
    check("f3_010_pcsrc", PC_SOURCE, 2'b00);
    check("f3_010_taken", BR_TAKEN, 1'b0);
    tick();
    check("f3_010_mp", MISPREDICT, 1'b0);
    IR_FUNCT = 3'b011; settle();
    check("f3_011_pcsrc", PC_SOURCE, 2'b00);
    IR_OPCODE = 7'b0110011; IR_FUNCT = 3'b000; settle();
    check("alu_pcsrc", PC_SOURCE, 2'b00);
    tick();
    check("nobr_pred", IF_PRED_TAKEN, 1'b1);
    check("nobr_br", BR_COUNT, 7);
    check("nobr_miss", MISS_COUNT, 4);

    // Same-cycle lookup/update on a fresh entry (0x44)
    IF_PC = 32'h44;
    drive(1'b1, OPB, 3'b000, 32'd7, 32'd7, 32'h44, 1'b0); settle();
    check("sc44_pre", IF_PRED_TAKEN, 1'b0);
    tick();
    check("sc44_post", IF_PRED_TAKEN, 1'b1);
    check("sc44_br", BR_COUNT, 8);
    check("sc44_miss", MISS_COUNT, 5);

    // Reset concurrent with a mispredicting update at 0x48
    IF_PC = 32'h48;
    drive(1'b1, OPB, 3'b000, 32'd7, 32'd7, 32'h48, 1'b0);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    EX_VALID = 1'b0;
    settle();
    check("rstupd_pred", IF_PRED_TAKEN, 1'b0);
    check("rstupd_mp", MISPREDICT, 1'b0);
    check("rstupd_br", BR_COUNT, 0);
    check("rstupd_miss", MISS_COUNT, 0);
    IF_PC = 32'h40; settle();
    check("rstupd_pred40", IF_PRED_TAKEN, 1'b0);

    // Counter saturation: 2^CNT_W + 3 mispredicting branches
    drive(1'b1, OPB, 3'b000, 32'd1, 32'd1, 32'h100, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      tick();
      if (i == 1)  check("b2b_mp", MISPREDICT, 1'b1);
      if (i == 13) check("cnt14_br", BR_COUNT, 14);
      if (i == 14) check("cnt15_br", BR_COUNT, 15);
    end
    check("sat_br", BR_COUNT, 15);
    check("sat_miss", MISS_COUNT, 15);
    check("sat_mp", MISPREDICT, 1'b1);
    EX_VALID = 1'b0;
    tick();
    check("sat_mp_end", MISPREDICT, 1'b0);
    check("sat_br_hold", BR_COUNT, 15);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
